// File: rtl/mux4_rr_sched.sv
// mux4_rr_sched
//   Round-robin scheduler sharing one 4:1 select path among four requesters.
//   Drives the S1/S0 selects of a downstream mux4_1 and a one-hot grant back
//   to the requesters. Each tenure is capped at HOLD_MAX cycles, and a
//   one-cycle select-settle gap separates consecutive owners.
// Parameters
//   HOLD_MAX  max consecutive grant cycles per tenure (1..255)
//   CNT_W     hold counter width, 2**CNT_W > HOLD_MAX-1
// Ports
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   req      [3:0] level requests, held while the path is wanted
//   grant    [3:0] one-hot registered grant, zero when there is no owner
//   S0, S1   owner index bits to the mux4_1 selects
//   busy     high while a grant is active
//   expired  one-cycle pulse when a tenure is ended by the hold limit
module mux4_rr_sched #(
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic       S0,
  output logic       S1,
  output logic       busy,
  output logic       expired
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  state_t           state, state_nx;
  logic [3:0]       grant_nx;
  logic [1:0]       sel, sel_nx;
  logic [1:0]       ptr, ptr_nx;
  logic [CNT_W-1:0] hold_cnt, hold_nx;
  logic             busy_nx, expired_nx;
  logic [1:0]       winner;
  logic             any_req;

  // First requester at or after ptr, wrapping modulo 4.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    found  = 1'b0;
    winner = ptr;
    idx    = ptr;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
    any_req = found;
  end

  always_comb begin
    state_nx   = state;
    grant_nx   = grant;
    sel_nx     = sel;
    ptr_nx     = ptr;
    hold_nx    = hold_cnt;
    busy_nx    = busy;
    expired_nx = 1'b0;
    case (state)
      GRANT: begin
        if (!req[sel]) begin
          state_nx = GAP;
          grant_nx = '0;
          busy_nx  = 1'b0;
          ptr_nx   = sel + 2'd1;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nx   = GAP;
          grant_nx   = '0;
          busy_nx    = 1'b0;
          ptr_nx     = sel + 2'd1;
          expired_nx = 1'b1;
        end else begin
          hold_nx = hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        // IDLE and GAP arbitrate identically; selects move only with a new grant.
        if (any_req) begin
          state_nx = GRANT;
          grant_nx = 4'b0001 << winner;
          sel_nx   = winner;
          hold_nx  = '0;
          busy_nx  = 1'b1;
        end else begin
          state_nx = IDLE;
          grant_nx = '0;
          busy_nx  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      sel      <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      busy     <= 1'b0;
      expired  <= 1'b0;
    end else begin
      state    <= state_nx;
      grant    <= grant_nx;
      sel      <= sel_nx;
      ptr      <= ptr_nx;
      hold_cnt <= hold_nx;
      busy     <= busy_nx;
      expired  <= expired_nx;
    end
  end

  assign S0 = sel[0];
  assign S1 = sel[1];

endmodule
